// File: rtl/frame_serializer_if.sv
// frame_serializer_if: word handshake into the serializer
// master drives in_data/in_valid and samples in_ready; slave is the serializer side
interface frame_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic in_valid;
  logic in_ready;
  modport master(output in_data, output in_valid, input in_ready);
  modport slave(input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/frame_serializer.sv
// frame_serializer: parallel word to serial frame (preamble, data, idle gap)
// ports: clk, rst (async active-high), s (word handshake, slave side),
// databit/bit_valid (serial bit and its qualifier), frame_start/frame_end (boundary pulses), busy
module frame_serializer #(
  parameter int WIDTH = 8,
  parameter int PRE_LEN = 4,
  parameter logic [((PRE_LEN > 0) ? PRE_LEN : 1)-1:0] PREAMBLE = 4'b1010,
  parameter int GAP = 2,
  parameter bit MSB_FIRST = 1
) (
  input  logic clk,
  input  logic rst,
  frame_serializer_if.slave s,
  output logic databit,
  output logic bit_valid,
  output logic frame_start,
  output logic frame_end,
  output logic busy
);
  localparam int M1 = (PRE_LEN > WIDTH) ? PRE_LEN : WIDTH;
  localparam int M2 = (M1 > GAP) ? M1 : GAP;
  localparam int CW = $clog2(M2) + 1;
  localparam int FL = PRE_LEN + WIDTH;
  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_GAP} state_t;
  localparam state_t FIRST = (PRE_LEN > 0) ? S_PRE : S_DATA;
  state_t state, nxt_state;
  logic [CW-1:0] cnt, nxt_cnt;
  logic [FL-1:0] fr, nxt_fr, load;
  logic [WIDTH-1:0] ord;
  logic pre_last, data_last, gap_last, accept, nxt_bv, nxt_end;
  assign pre_last = cnt == CW'(PRE_LEN - 1);
  assign data_last = cnt == CW'(WIDTH - 1);
  assign gap_last = cnt == CW'(GAP - 1);
  assign s.in_ready = state == S_IDLE || (GAP > 0 && state == S_GAP && gap_last) ||
                      (GAP == 0 && state == S_DATA && data_last);
  assign accept = s.in_valid && s.in_ready;
  for (genvar i = 0; i < WIDTH; i++) begin : g_ord
    assign ord[i] = MSB_FIRST ? s.in_data[i] : s.in_data[WIDTH-1-i];
  end
  // whole frame is loaded at accept and shifted out MSB first; zeros fill behind it
  if (PRE_LEN > 0) begin : g_pre
    assign load = {PREAMBLE, ord};
  end else begin : g_nopre
    assign load = ord;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      fr <= '0;
      databit <= 1'b0;
      bit_valid <= 1'b0;
      frame_start <= 1'b0;
      frame_end <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= nxt_state;
      cnt <= nxt_cnt;
      fr <= nxt_fr;
      databit <= nxt_fr[FL-1];
      bit_valid <= nxt_bv;
      frame_start <= accept;
      frame_end <= nxt_end;
      busy <= nxt_state != S_IDLE;
    end
  end
  // acceptance only happens in IDLE or on the final tail cycle, so it always restarts a frame
  always_comb begin
    nxt_state = accept ? FIRST :
                state == S_PRE ? (pre_last ? S_DATA : S_PRE) :
                state == S_DATA ? (data_last ? ((GAP > 0) ? S_GAP : S_IDLE) : S_DATA) :
                state == S_GAP ? (gap_last ? S_IDLE : S_GAP) : S_IDLE;
    nxt_cnt = (accept || nxt_state != state || state == S_IDLE) ? '0 : cnt + 1'b1;
  end
  always_comb begin
    nxt_fr = accept ? load : fr << 1;
    nxt_bv = nxt_state == S_PRE || nxt_state == S_DATA;
    nxt_end = nxt_state == S_DATA && nxt_cnt == CW'(WIDTH - 1);
  end
endmodule

// File: tb/tb_frame_serializer.sv
// tb_frame_serializer: directed scoreboard bench over four serializer configurations
module tb_frame_serializer;
  typedef struct packed {logic db, bv, fs, fe, bz, rdy;} exp_t;
  localparam logic [3:0] PRE = 4'b1010;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] dat[4];
  logic vld[4];
  logic db[4], bv[4], fs[4], fe[4], bz[4], rdy[4];
  int pl[4] = '{4, 4, 4, 0};
  int gp[4] = '{2, 2, 0, 2};
  bit msb[4] = '{1, 0, 1, 1};
  exp_t q[$];
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  frame_serializer_if #(.WIDTH(8)) if0 ();
  frame_serializer_if #(.WIDTH(8)) if1 ();
  frame_serializer_if #(.WIDTH(8)) if2 ();
  frame_serializer_if #(.WIDTH(8)) if3 ();
  assign if0.in_data = dat[0];
  assign if0.in_valid = vld[0];
  assign rdy[0] = if0.in_ready;
  assign if1.in_data = dat[1];
  assign if1.in_valid = vld[1];
  assign rdy[1] = if1.in_ready;
  assign if2.in_data = dat[2];
  assign if2.in_valid = vld[2];
  assign rdy[2] = if2.in_ready;
  assign if3.in_data = dat[3];
  assign if3.in_valid = vld[3];
  assign rdy[3] = if3.in_ready;
  frame_serializer u0 (.clk(clk), .rst(rst), .s(if0.slave), .databit(db[0]), .bit_valid(bv[0]),
                       .frame_start(fs[0]), .frame_end(fe[0]), .busy(bz[0]));
  frame_serializer #(.MSB_FIRST(0)) u1 (.clk(clk), .rst(rst), .s(if1.slave), .databit(db[1]),
                       .bit_valid(bv[1]), .frame_start(fs[1]), .frame_end(fe[1]), .busy(bz[1]));
  frame_serializer #(.GAP(0)) u2 (.clk(clk), .rst(rst), .s(if2.slave), .databit(db[2]),
                       .bit_valid(bv[2]), .frame_start(fs[2]), .frame_end(fe[2]), .busy(bz[2]));
  frame_serializer #(.PRE_LEN(0), .PREAMBLE(1'b0)) u3 (.clk(clk), .rst(rst), .s(if3.slave),
                       .databit(db[3]), .bit_valid(bv[3]), .frame_start(fs[3]),
                       .frame_end(fe[3]), .busy(bz[3]));
  task automatic chk(string tag, logic obs, logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask
  task automatic cmp(int k, string tag, exp_t e);
    chk({tag, "/databit"}, db[k], e.db);
    chk({tag, "/bit_valid"}, bv[k], e.bv);
    chk({tag, "/frame_start"}, fs[k], e.fs);
    chk({tag, "/frame_end"}, fe[k], e.fe);
    chk({tag, "/busy"}, bz[k], e.bz);
    chk({tag, "/in_ready"}, rdy[k], e.rdy);
  endtask
  task automatic push_frame(int k, logic [7:0] w);
    int n;
    exp_t e;
    n = pl[k] + 8 + gp[k];
    for (int c = 0; c < n; c++) begin
      e = '0;
      e.bz = 1'b1;
      e.rdy = c == n - 1;
      if (c < pl[k]) begin
        e.db = 1'(PRE >> (pl[k] - 1 - c));
        e.bv = 1'b1;
        e.fs = c == 0;
      end else if (c < pl[k] + 8) begin
        e.db = 1'(w >> (msb[k] ? 7 - (c - pl[k]) : c - pl[k]));
        e.bv = 1'b1;
        e.fs = c == 0;
        e.fe = c - pl[k] == 7;
      end
      q.push_back(e);
    end
  endtask
  task automatic run(int k, string tag, logic [7:0] w0, logic [7:0] w1, int nw);
    logic [7:0] ws[2];
    int idx;
    bit acc;
    exp_t e;
    ws[0] = w0;
    ws[1] = w1;
    idx = 0;
    for (int i = 0; i < nw; i++) push_frame(k, ws[i]);
    @(negedge clk);
    chk({tag, "/ready_idle"}, rdy[k], 1'b1);
    dat[k] = ws[0];
    vld[k] = 1'b1;
    acc = 1'b1;
    while (q.size() > 0) begin
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < nw) dat[k] = ws[idx];
        else begin
          vld[k] = 1'b0;
          dat[k] = ~dat[k];
        end
      end
      e = q.pop_front();
      cmp(k, tag, e);
      acc = e.rdy && vld[k];
    end
    @(posedge clk);
    #1;
    cmp(k, {tag, "/after"}, 6'b000001);
  endtask
  initial begin
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      vld[k] = 1'b0;
      dat[k] = '0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) cmp(k, "reset", 6'b000001);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) cmp(k, "idle", 6'b000001);
    end
    run(0, "a5", 8'hA5, 8'h00, 1);
    run(1, "lsb_1e", 8'h1E, 8'h00, 1);
    run(2, "b2b", 8'hFF, 8'h00, 2);
    run(3, "nopre_80", 8'h80, 8'h00, 1);
    push_frame(0, 8'h5A);
    @(negedge clk);
    dat[0] = 8'h5A;
    vld[0] = 1'b1;
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      e = q.pop_front();
      cmp(0, "pre_abort", e);
    end
    #3 rst = 1'b1;
    #1 cmp(0, "async_rst", 6'b000001);
    q.delete();
    #2 rst = 1'b0;
    run(0, "after_rst_3c", 8'h3C, 8'h00, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
